// File: rtl/jtkiwi_sub_bus.sv
// Kiwi sub Z80 bus controller.
// Registers the address decode for ROM, shared RAM, FM and input ports.
// Drives the sub-side port of the shared RAM and generates wait states.
// Also handles the vblank interrupt and the CPU reset sequencer.
module jtkiwi_sub_bus #(
    parameter int RSTLEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        snd_rstn,
    input  logic        LVBL,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        m1_n,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic [7:0]  cpu_din,
    output logic        wait_n,
    output logic        int_n,
    output logic        cpu_rstn,
    output logic [12:0] shr_addr,
    output logic [7:0]  shr_din,
    output logic        shr_we,
    input  logic [7:0]  shr_dout,
    output logic        fm_cs,
    input  logic [7:0]  fm_dout,
    output logic [16:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [7:0]  rom_data,
    input  logic [15:0] dipsw,
    input  logic [6:0]  joy1,
    input  logic [6:0]  joy2,
    input  logic [1:0]  coin,
    input  logic [1:0]  start
);

    localparam int             CW      = $clog2(RSTLEN + 1);
    localparam logic [CW-1:0]  RST_MAX = CW'(RSTLEN);

    // Reset sequencer state
    logic [1:0]    sync_r;
    logic [CW-1:0] rst_cnt_r;
    logic [CW-1:0] rst_cnt_s;
    logic          rstn_next_s;
    logic          cpu_rstn_r;

    // Decode state
    logic          rom_fix_s, rom_bnk_s, shr_s, fm_s, bank_wr_s, io_s, shr_rd_s;
    logic [7:0]    io_data_s;
    logic [1:0]    bank_r;
    logic          rom_cs_r, fm_cs_r, shr_we_r, shr_rd_r, io_cs_r;
    logic [16:0]   rom_addr_r;
    logic [12:0]   shr_addr_r;
    logic [7:0]    shr_din_r;
    logic [7:0]    io_data_r;
    logic [1:0]    shr_wcnt_r;
    logic [7:0]    cpu_din_r;

    // Interrupt state
    logic          lvbl_r;
    logic          int_n_r;
    logic          ack_s;

    // Synchronise the main CPU reset request into the clk domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], snd_rstn};
        end
    end

    // Next counter value: cleared while the request is low, saturates at RSTLEN
    always_comb begin
        rst_cnt_s = rst_cnt_r;
        if (!sync_r[1]) begin
            rst_cnt_s = {CW{1'b0}};
        end else if (cen && (rst_cnt_r != RST_MAX)) begin
            rst_cnt_s = rst_cnt_r + CW'(1);
        end else begin
            rst_cnt_s = rst_cnt_r;
        end
        rstn_next_s = sync_r[1] && (rst_cnt_s == RST_MAX);
    end

    // Reset counter and registered CPU reset output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt_r  <= {CW{1'b0}};
            cpu_rstn_r <= 1'b0;
        end else begin
            rst_cnt_r  <= rst_cnt_s;
            cpu_rstn_r <= rstn_next_s;
        end
    end

    // Address decode; ROM needs rd_n so refresh cycles do not fetch
    always_comb begin
        rom_fix_s = !mreq_n && !rd_n && (A[15] == 1'b0);
        rom_bnk_s = !mreq_n && !rd_n && (A[15:14] == 2'b10);
        shr_s     = !mreq_n && (A[15:13] == 3'b110);
        shr_rd_s  = shr_s && !rd_n;
        fm_s      = !mreq_n && (A[15:1] == 15'h7000);
        bank_wr_s = !mreq_n && !wr_n && (A == 16'hF000);
        io_s      = !mreq_n && !rd_n && (A[15:3] == 13'h1F00) && (A[2:0] <= 3'd4);
    end

    // Input port multiplexer
    always_comb begin
        io_data_s = 8'hFF;
        case (A[2:0])
            3'd0:    io_data_s = dipsw[7:0];
            3'd1:    io_data_s = dipsw[15:8];
            3'd2:    io_data_s = {1'b1, joy1};
            3'd3:    io_data_s = {1'b1, joy2};
            3'd4:    io_data_s = {coin, start, 4'hF};
            default: io_data_s = 8'hFF;
        endcase
    end

    // Registered decode; everything is cleared while the CPU is (about to be) in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_r     <= 2'b00;
            rom_cs_r   <= 1'b0;
            rom_addr_r <= 17'd0;
            fm_cs_r    <= 1'b0;
            shr_we_r   <= 1'b0;
            shr_rd_r   <= 1'b0;
            shr_addr_r <= 13'd0;
            shr_din_r  <= 8'd0;
            shr_wcnt_r <= 2'd0;
            io_cs_r    <= 1'b0;
            io_data_r  <= 8'hFF;
        end else if (!rstn_next_s) begin
            bank_r     <= 2'b00;
            rom_cs_r   <= 1'b0;
            fm_cs_r    <= 1'b0;
            shr_we_r   <= 1'b0;
            shr_rd_r   <= 1'b0;
            shr_wcnt_r <= 2'd0;
            io_cs_r    <= 1'b0;
        end else begin
            if (bank_wr_s) begin
                bank_r <= cpu_dout[1:0];
            end
            rom_cs_r <= rom_fix_s || rom_bnk_s;
            if (rom_fix_s) begin
                rom_addr_r <= {2'b00, A[14:0]};
            end else if (rom_bnk_s) begin
                rom_addr_r <= {1'b1, bank_r, A[13:0]};
            end
            fm_cs_r  <= fm_s;
            shr_we_r <= shr_s && !wr_n;
            shr_rd_r <= shr_rd_s;
            if (shr_s) begin
                shr_addr_r <= A[12:0];
                shr_din_r  <= cpu_dout;
            end
            // Two wait clocks from the first decoded clk of a shared read
            if (shr_rd_s && !shr_rd_r) begin
                shr_wcnt_r <= 2'd2;
            end else if (shr_wcnt_r != 2'd0) begin
                shr_wcnt_r <= shr_wcnt_r - 2'd1;
            end
            io_cs_r   <= io_s;
            io_data_r <= io_data_s;
        end
    end

    // Read data register: ROM first, default FF
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_din_r <= 8'hFF;
        end else if (rom_cs_r) begin
            cpu_din_r <= rom_data;
        end else if (shr_rd_r) begin
            cpu_din_r <= shr_dout;
        end else if (fm_cs_r) begin
            cpu_din_r <= fm_dout;
        end else if (io_cs_r) begin
            cpu_din_r <= io_data_r;
        end else begin
            cpu_din_r <= 8'hFF;
        end
    end

    assign ack_s = !iorq_n && !m1_n;

    // Vblank interrupt: acknowledge or CPU reset beats a new edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvbl_r  <= 1'b1;
            int_n_r <= 1'b1;
        end else begin
            lvbl_r <= LVBL;
            if (!cpu_rstn_r || ack_s) begin
                int_n_r <= 1'b1;
            end else if (lvbl_r && !LVBL) begin
                int_n_r <= 1'b0;
            end else begin
                int_n_r <= int_n_r;
            end
        end
    end

    // ROM wait must follow rom_ok in the same clk, so it is formed from registered cs
    assign wait_n   = ~((rom_cs_r & ~rom_ok) | (shr_wcnt_r != 2'd0));
    assign cpu_din  = cpu_din_r;
    assign int_n    = int_n_r;
    assign cpu_rstn = cpu_rstn_r;
    assign shr_addr = shr_addr_r;
    assign shr_din  = shr_din_r;
    assign shr_we   = shr_we_r;
    assign fm_cs    = fm_cs_r;
    assign rom_addr = rom_addr_r;
    assign rom_cs   = rom_cs_r;

endmodule

// File: tb/tb_jtkiwi_sub_bus.sv
// Directed self-checking bench for jtkiwi_sub_bus.
module tb_jtkiwi_sub_bus;

    logic        clk, rst, cen, snd_rstn, LVBL;
    logic [15:0] A;
    logic [7:0]  cpu_dout;
    logic        mreq_n, iorq_n, m1_n, rd_n, wr_n;
    logic [7:0]  cpu_din;
    logic        wait_n, int_n, cpu_rstn;
    logic [12:0] shr_addr;
    logic [7:0]  shr_din;
    logic        shr_we;
    logic [7:0]  shr_dout;
    logic        fm_cs;
    logic [7:0]  fm_dout;
    logic [16:0] rom_addr;
    logic        rom_cs, rom_ok;
    logic [7:0]  rom_data;
    logic [15:0] dipsw;
    logic [6:0]  joy1, joy2;
    logic [1:0]  coin, start;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cen_edges = 0;
    logic [7:0] mem [0:8191];

    jtkiwi_sub_bus #(.RSTLEN(16)) dut (
        .clk(clk), .rst(rst), .cen(cen), .snd_rstn(snd_rstn), .LVBL(LVBL),
        .A(A), .cpu_dout(cpu_dout), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n), .cpu_din(cpu_din),
        .wait_n(wait_n), .int_n(int_n), .cpu_rstn(cpu_rstn),
        .shr_addr(shr_addr), .shr_din(shr_din), .shr_we(shr_we),
        .shr_dout(shr_dout), .fm_cs(fm_cs), .fm_dout(fm_dout),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok),
        .rom_data(rom_data), .dipsw(dipsw), .joy1(joy1), .joy2(joy2),
        .coin(coin), .start(start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared RAM model with one clk read latency
    always @(posedge clk) begin
        if (shr_we) mem[shr_addr] <= shr_din;
        shr_dout <= mem[shr_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; cen is high one clk in four
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (cen) cen_edges++;
            #1;
            cyc++;
            cen = ((cyc % 4) == 0);
        end
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
    endtask

    task automatic mem_read(input logic [15:0] addr);
        A = addr; mreq_n = 1'b0; rd_n = 1'b1; wr_n = 1'b1; rd_n = 1'b0;
    endtask

    task automatic mem_write(input logic [15:0] addr, input logic [7:0] d);
        A = addr; cpu_dout = d; mreq_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0;
    endtask

    // Raise snd_rstn and check cpu_rstn rises on the 16th cen after the 2-clk sync
    task automatic release_cpu(input string tag);
        int base;
        int guard;
        snd_rstn = 1'b1;
        step(2);
        base  = cen_edges;
        guard = 0;
        while ((cen_edges - base) < 15 && guard < 200) begin
            step(1);
            guard++;
        end
        chk({tag, "_pre"}, {31'd0, cpu_rstn}, 32'd0);
        while ((cen_edges - base) < 16 && guard < 200) begin
            step(1);
            guard++;
        end
        chk({tag, "_rise"}, {31'd0, cpu_rstn}, 32'd1);
        chk({tag, "_bound"}, {31'd0, (guard < 200)}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; snd_rstn = 1'b0; LVBL = 1'b1;
        A = 16'h0000; cpu_dout = 8'h00; rom_ok = 1'b0; rom_data = 8'h00;
        fm_dout = 8'h77; dipsw = 16'hA55A; joy1 = 7'h7E; joy2 = 7'h7F;
        coin = 2'b10; start = 2'b01;
        bus_idle();
        step(3);
        chk("rst_cpu_rstn", {31'd0, cpu_rstn}, 32'd0);
        chk("rst_int_n",    {31'd0, int_n},    32'd1);
        chk("rst_wait_n",   {31'd0, wait_n},   32'd1);
        chk("rst_rom_cs",   {31'd0, rom_cs},   32'd0);
        chk("rst_fm_cs",    {31'd0, fm_cs},    32'd0);
        chk("rst_shr_we",   {31'd0, shr_we},   32'd0);
        chk("rst_cpu_din",  {24'd0, cpu_din},  32'hFF);
        chk("rst_rom_addr", {15'd0, rom_addr}, 32'd0);
        rst = 1'b0;
        step(2);

        // Reset release, then a drop mid-count restarts the count
        release_cpu("boot");
        snd_rstn = 1'b0;
        step(3);
        chk("drop_rstn", {31'd0, cpu_rstn}, 32'd0);
        snd_rstn = 1'b1;
        step(30);
        chk("partial_rstn", {31'd0, cpu_rstn}, 32'd0);
        snd_rstn = 1'b0;
        step(4);
        release_cpu("restart");

        // Banking and ROM wait
        mem_write(16'hF000, 8'h02);
        step(1);
        bus_idle();
        step(1);
        rom_ok = 1'b0;
        mem_read(16'h9234);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("rom_wait", {31'd0, wait_n}, 32'd0);
        end
        chk("rom_bank_addr", {15'd0, rom_addr}, 32'h19234);
        chk("rom_cs", {31'd0, rom_cs}, 32'd1);
        rom_ok = 1'b1; rom_data = 8'h3C;
        #1;
        chk("rom_ok_wait", {31'd0, wait_n}, 32'd1);
        step(1);
        chk("rom_din", {24'd0, cpu_din}, 32'h3C);
        bus_idle();
        step(1);
        mem_read(16'h1234);
        step(1);
        chk("rom_fix_addr", {15'd0, rom_addr}, 32'h01234);
        bus_idle();
        step(1);

        // Shared RAM write then read
        mem_write(16'hC123, 8'h5A);
        step(1);
        chk("shr_we",   {31'd0, shr_we},   32'd1);
        chk("shr_addr", {19'd0, shr_addr}, 32'h0123);
        chk("shr_din",  {24'd0, shr_din},  32'h5A);
        chk("shr_wr_wait", {31'd0, wait_n}, 32'd1);
        bus_idle();
        step(1);
        chk("shr_we_off", {31'd0, shr_we}, 32'd0);
        mem_read(16'hC123);
        step(1);
        chk("shr_wait1", {31'd0, wait_n}, 32'd0);
        step(1);
        chk("shr_wait2", {31'd0, wait_n}, 32'd0);
        step(1);
        chk("shr_wait_end", {31'd0, wait_n}, 32'd1);
        chk("shr_rd_din", {24'd0, cpu_din}, 32'h5A);
        bus_idle();
        step(1);

        // Input ports and unmapped read
        mem_read(16'hF800); step(2);
        chk("port_f800", {24'd0, cpu_din}, 32'h5A);
        mem_read(16'hF801); step(2);
        chk("port_f801", {24'd0, cpu_din}, 32'hA5);
        mem_read(16'hF802); step(2);
        chk("port_f802", {24'd0, cpu_din}, 32'hFE);
        mem_read(16'hF804); step(2);
        chk("port_f804", {24'd0, cpu_din}, 32'h9F);
        mem_read(16'hF900); step(2);
        chk("port_f900", {24'd0, cpu_din}, 32'hFF);
        mem_read(16'hE001); step(1);
        chk("fm_cs", {31'd0, fm_cs}, 32'd1);
        step(1);
        chk("fm_din", {24'd0, cpu_din}, 32'h77);
        bus_idle();
        step(1);
        chk("fm_cs_off", {31'd0, fm_cs}, 32'd0);

        // Interrupt
        LVBL = 1'b0; step(1);
        chk("irq_set", {31'd0, int_n}, 32'd0);
        LVBL = 1'b1; step(2);
        chk("irq_hold", {31'd0, int_n}, 32'd0);
        iorq_n = 1'b0; m1_n = 1'b0; step(1);
        chk("irq_ack", {31'd0, int_n}, 32'd1);
        bus_idle(); step(1);
        LVBL = 1'b0; iorq_n = 1'b0; m1_n = 1'b0; step(1);
        chk("irq_ack_wins", {31'd0, int_n}, 32'd1);
        bus_idle(); step(2);
        chk("irq_ack_wins2", {31'd0, int_n}, 32'd1);
        LVBL = 1'b1; step(1);

        // Mid-access reset during a shared read wait
        mem_read(16'hC123);
        step(1);
        chk("mid_wait", {31'd0, wait_n}, 32'd0);
        snd_rstn = 1'b0;
        step(3);
        chk("mid_rstn", {31'd0, cpu_rstn}, 32'd0);
        chk("mid_wait_rel", {31'd0, wait_n}, 32'd1);
        mem_write(16'hC050, 8'h11);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("mid_no_we", {31'd0, shr_we}, 32'd0);
        end
        bus_idle();
        step(1);
        release_cpu("rerelease");
        mem_read(16'h9234);
        rom_ok = 1'b1;
        step(1);
        chk("bank_cleared", {15'd0, rom_addr}, 32'h11234);
        bus_idle();
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
